// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage with byte-addressed little-endian data
//               memory and the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_exmem_out,
    input  logic [31:0] RD2_exmem_out,
    input  logic [4:0]  A3_exmem_out,
    input  logic [2:0]  funct3_exmem_out,
    input  logic        RegWriteM,
    input  logic [1:0]  MEM_CtrlM,
    input  logic        stall,
    output logic [31:0] read_data_W,
    output logic [31:0] alu_W,
    output logic [4:0]  A3_W,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic        access_fault_W
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);

    logic [31:0]        r_mem [MEM_WORDS];

    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_mem_write;
    logic               w_mem_to_reg;
    logic               w_fault;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ext;
    logic [31:0]        w_load_data;
    logic               w_unused_addr;

    assign w_idx         = alu_exmem_out[c_IDX_W+1:2];
    assign w_off         = alu_exmem_out[1:0];
    assign w_unused_addr = ^alu_exmem_out[31:c_IDX_W+2];

    // A combined store+load request behaves as a plain store.
    assign w_mem_write  = MEM_CtrlM[0];
    assign w_mem_to_reg = MEM_CtrlM[1] & ~MEM_CtrlM[0];

    always_comb begin
        w_fault = 1'b0;
        if (w_mem_write) begin
            case (funct3_exmem_out)
                3'b000:  w_fault = 1'b0;
                3'b001:  w_fault = w_off[0];
                3'b010:  w_fault = (w_off != 2'b00);
                default: w_fault = 1'b1;
            endcase
        end else if (w_mem_to_reg) begin
            case (funct3_exmem_out)
                3'b000, 3'b100: w_fault = 1'b0;
                3'b001, 3'b101: w_fault = w_off[0];
                3'b010:         w_fault = (w_off != 2'b00);
                default:        w_fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = RD2_exmem_out;
        case (funct3_exmem_out[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{RD2_exmem_out[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{RD2_exmem_out[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = RD2_exmem_out;
            end
        endcase
    end

    assign w_we = w_mem_write & ~w_fault & ~stall & ~rst;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_rword = r_mem[w_idx];
    assign w_half  = w_off[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    always_comb begin
        case (funct3_exmem_out)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = w_rword;
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = 32'h0;
        endcase
    end

    assign w_load_data = (w_mem_to_reg & ~w_fault) ? w_ext : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_W    <= 32'h0;
            alu_W          <= 32'h0;
            A3_W           <= 5'h0;
            RegWriteW      <= 1'b0;
            MemToRegW      <= 1'b0;
            access_fault_W <= 1'b0;
        end else if (!stall) begin
            read_data_W    <= w_load_data;
            alu_W          <= alu_exmem_out;
            A3_W           <= A3_exmem_out;
            RegWriteW      <= RegWriteM & ~w_fault;
            MemToRegW      <= w_mem_to_reg;
            access_fault_W <= w_fault;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard testbench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam logic [2:0] c_B   = 3'b000;
    localparam logic [2:0] c_H   = 3'b001;
    localparam logic [2:0] c_W   = 3'b010;
    localparam logic [2:0] c_BU  = 3'b100;
    localparam logic [2:0] c_HU  = 3'b101;
    localparam logic [2:0] c_BAD = 3'b011;
    localparam logic [1:0] c_NA  = 2'b00;
    localparam logic [1:0] c_ST  = 2'b01;
    localparam logic [1:0] c_LD  = 2'b10;
    localparam logic [1:0] c_SL  = 2'b11;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  a3;
        logic        rw;
        logic        mtr;
        logic        flt;
    } out_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  a3;
        logic [2:0]  f3;
        logic        rw;
        logic [1:0]  ctrl;
        logic        stl;
        logic        rs;
        out_t        exp;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_exmem_out = '0;
    logic [31:0] RD2_exmem_out = '0;
    logic [4:0]  A3_exmem_out = '0;
    logic [2:0]  funct3_exmem_out = '0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  MEM_CtrlM = '0;
    logic        stall = 1'b0;
    logic [31:0] read_data_W;
    logic [31:0] alu_W;
    logic [4:0]  A3_W;
    logic        RegWriteW;
    logic        MemToRegW;
    logic        access_fault_W;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];

    mem_stage #(.MEM_WORDS(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_exmem_out   (alu_exmem_out),
        .RD2_exmem_out   (RD2_exmem_out),
        .A3_exmem_out    (A3_exmem_out),
        .funct3_exmem_out(funct3_exmem_out),
        .RegWriteM       (RegWriteM),
        .MEM_CtrlM       (MEM_CtrlM),
        .stall           (stall),
        .read_data_W     (read_data_W),
        .alu_W           (alu_W),
        .A3_W            (A3_W),
        .RegWriteW       (RegWriteW),
        .MemToRegW       (MemToRegW),
        .access_fault_W  (access_fault_W)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] a3, input logic [2:0] f3,
                               input logic rw, input logic [1:0] ctrl,
                               input logic stl, input logic rs,
                               input logic [31:0] erd, input logic [31:0] ealu,
                               input logic [4:0] ea3, input logic erw,
                               input logic emtr, input logic eflt);
        op_t o;
        o.addr = addr; o.data = data; o.a3 = a3; o.f3 = f3;
        o.rw = rw; o.ctrl = ctrl; o.stl = stl; o.rs = rs;
        o.exp.rd = erd; o.exp.alu = ealu; o.exp.a3 = ea3;
        o.exp.rw = erw; o.exp.mtr = emtr; o.exp.flt = eflt;
        return o;
    endfunction

    function automatic out_t outs();
        outs = {read_data_W, alu_W, A3_W, RegWriteW, MemToRegW, access_fault_W};
    endfunction

    // Drive one request at the falling edge, queue its expected WB result,
    // and return 1 ns after the capturing rising edge.
    task automatic apply(input op_t o);
        @(negedge clk);
        alu_exmem_out    = o.addr;
        RD2_exmem_out    = o.data;
        A3_exmem_out     = o.a3;
        funct3_exmem_out = o.f3;
        RegWriteM        = o.rw;
        MEM_CtrlM        = o.ctrl;
        stall            = o.stl;
        rst              = o.rs;
        sb.push_back(o.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op_t ops[$];
        ops.push_back(mk(32'hFFFF_FFFF, 32'h1, 5'd31, c_W, 1, c_NA, 1, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h10, 32'h1, 5'd31, c_W, 1, c_LD, 0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_word();
        op_t ops[$];
        ops.push_back(mk(32'h10, 32'hDEADBEEF, 5'd0, c_W, 0, c_ST, 0, 0, 32'h0, 32'h10, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd5, c_W, 1, c_LD, 0, 0, 32'hDEADBEEF, 32'h10, 5'd5, 1, 1, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL word[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_byte();
        op_t ops[$];
        ops.push_back(mk(32'h13, 32'hAAAA_AA7F, 5'd0, c_B, 0, c_ST, 0, 0, 32'h0, 32'h13, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd6, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h10, 5'd6, 1, 1, 0));
        ops.push_back(mk(32'h11, 32'h0, 5'd7, c_B, 1, c_LD, 0, 0, 32'hFFFFFFBE, 32'h11, 5'd7, 1, 1, 0));
        ops.push_back(mk(32'h11, 32'h0, 5'd8, c_BU, 1, c_LD, 0, 0, 32'h000000BE, 32'h11, 5'd8, 1, 1, 0));
        ops.push_back(mk(32'h13, 32'h0, 5'd9, c_BU, 1, c_LD, 0, 0, 32'h0000007F, 32'h13, 5'd9, 1, 1, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL byte[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_half();
        op_t ops[$];
        ops.push_back(mk(32'h20, 32'hAAAA5555, 5'd0, c_W, 0, c_ST, 0, 0, 32'h0, 32'h20, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h22, 32'h12348001, 5'd0, c_H, 0, c_ST, 0, 0, 32'h0, 32'h22, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h20, 32'h0, 5'd8, c_W, 1, c_LD, 0, 0, 32'h80015555, 32'h20, 5'd8, 1, 1, 0));
        ops.push_back(mk(32'h22, 32'h0, 5'd9, c_H, 1, c_LD, 0, 0, 32'hFFFF8001, 32'h22, 5'd9, 1, 1, 0));
        ops.push_back(mk(32'h22, 32'h0, 5'd10, c_HU, 1, c_LD, 0, 0, 32'h00008001, 32'h22, 5'd10, 1, 1, 0));
        ops.push_back(mk(32'h20, 32'h0, 5'd11, c_HU, 1, c_LD, 0, 0, 32'h00005555, 32'h20, 5'd11, 1, 1, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL half[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_fault();
        op_t ops[$];
        ops.push_back(mk(32'h12, 32'h0, 5'd7, c_W, 1, c_LD, 0, 0, 32'h0, 32'h12, 5'd7, 0, 1, 1));
        ops.push_back(mk(32'h11, 32'hFFFFFFFF, 5'd0, c_W, 0, c_ST, 0, 0, 32'h0, 32'h11, 5'd0, 0, 0, 1));
        ops.push_back(mk(32'h10, 32'h0, 5'd2, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h10, 5'd2, 1, 1, 0));
        ops.push_back(mk(32'h21, 32'h0, 5'd3, c_H, 1, c_LD, 0, 0, 32'h0, 32'h21, 5'd3, 0, 1, 1));
        ops.push_back(mk(32'h10, 32'h0, 5'd0, c_BU, 0, c_ST, 0, 0, 32'h0, 32'h10, 5'd0, 0, 0, 1));
        ops.push_back(mk(32'h10, 32'h0, 5'd2, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h10, 5'd2, 1, 1, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd4, c_BAD, 1, c_LD, 0, 0, 32'h0, 32'h10, 5'd4, 0, 1, 1));
        ops.push_back(mk(32'h12, 32'h0, 5'd3, c_BAD, 1, c_NA, 0, 0, 32'h0, 32'h12, 5'd3, 1, 0, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL fault[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_stall_rst();
        op_t ops[$];
        ops.push_back(mk(32'h55, 32'h0, 5'd9, c_W, 1, c_NA, 0, 0, 32'h0, 32'h55, 5'd9, 1, 0, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd1, c_W, 0, c_ST, 1, 0, 32'h0, 32'h55, 5'd9, 1, 0, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd1, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h10, 5'd1, 1, 1, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd1, c_W, 1, c_LD, 1, 0, 32'h7FADBEEF, 32'h10, 5'd1, 1, 1, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd1, c_W, 1, c_ST, 0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd2, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h10, 5'd2, 1, 1, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd2, c_W, 1, c_ST, 1, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h10, 32'h0, 5'd3, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h10, 5'd3, 1, 1, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL stall_rst[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_wrap();
        op_t ops[$];
        ops.push_back(mk(32'h400, 32'h12345678, 5'd0, c_W, 0, c_ST, 0, 0, 32'h0, 32'h400, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h000, 32'h0, 5'd1, c_W, 1, c_LD, 0, 0, 32'h12345678, 32'h0, 5'd1, 1, 1, 0));
        ops.push_back(mk(32'h403, 32'h0, 5'd2, c_BU, 1, c_LD, 0, 0, 32'h00000012, 32'h403, 5'd2, 1, 1, 0));
        ops.push_back(mk(32'h410, 32'h0, 5'd3, c_W, 1, c_LD, 0, 0, 32'h7FADBEEF, 32'h410, 5'd3, 1, 1, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        ops.push_back(mk(32'h30, 32'h11223344, 5'd4, c_W, 0, c_SL, 0, 0, 32'h0, 32'h30, 5'd4, 0, 0, 0));
        ops.push_back(mk(32'h30, 32'h0, 5'd5, c_W, 1, c_LD, 0, 0, 32'h11223344, 32'h30, 5'd5, 1, 1, 0));
        ops.push_back(mk(32'h31, 32'h00000080, 5'd0, c_B, 0, c_ST, 0, 0, 32'h0, 32'h31, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h31, 32'h0, 5'd6, c_B, 1, c_LD, 0, 0, 32'hFFFFFF80, 32'h31, 5'd6, 1, 1, 0));
        ops.push_back(mk(32'h30, 32'h0000BEEF, 5'd0, c_H, 0, c_ST, 0, 0, 32'h0, 32'h30, 5'd0, 0, 0, 0));
        ops.push_back(mk(32'h30, 32'h0, 5'd7, c_HU, 1, c_LD, 0, 0, 32'h0000BEEF, 32'h30, 5'd7, 1, 1, 0));
        ops.push_back(mk(32'h30, 32'h0, 5'd8, c_W, 1, c_LD, 0, 0, 32'h1122BEEF, 32'h30, 5'd8, 1, 1, 0));
        foreach (ops[i]) begin
            out_t e;
            apply(ops[i]);
            e = sb.pop_front();
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, outs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_stall_rst();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
